// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - shared Gray/binary helpers for the async FIFO pointer generators
//
// Purpose: Gray <-> binary conversion functions and common constants used by
//          both sides of the async FIFO. Functions work on a MAX_W-bit
//          container; callers zero-extend their pointer and truncate the
//          result back to their pointer width.
// Contents:
//   MAX_W       widest pointer the helpers accept
//   DEF_ADDR_W  default RAM address width
//   DEPTH       default FIFO depth (2**DEF_ADDR_W)
//   bin2gray    binary -> Gray
//   gray2bin    Gray -> binary (prefix XOR built from doubling shifts)
package fifo_ptr_pkg;

  localparam int MAX_W      = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each bit of the binary value is the XOR of itself and every higher Gray
  // bit; folding with shifts of 1, 2, 4, ... builds that prefix XOR in
  // log2(MAX_W) steps.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - multi-flop synchroniser for a Gray pointer crossing clock domains
//
// Purpose: STAGES-deep flop chain that brings the opposite domain's Gray
//          pointer into clk. Kept as its own module so the crossing is easy
//          to find and constrain.
// Ports:
//   clk   in   1   destination clock
//   rst   in   1   asynchronous active-high reset, clears every stage
//   d     in   W   Gray pointer from the other domain (asynchronous to clk)
//   q     out  W   synchronised pointer, STAGES cycles behind d
module ptr_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_gen.sv
// rtl/gray_ptr_gen.sv - one side of an async FIFO: Gray pointer, full/empty flag, level
//
// Purpose: binary pointer counter with a registered Gray copy for the other
//          domain, a synchroniser for the other side's Gray pointer, and the
//          registered full (write side) or empty (read side) flag plus the
//          occupancy seen from this side.
// Parameters:
//   ADDR_W       RAM address width; pointers carry one extra wrap bit
//   IS_WRITE     1: write side, flag = full; 0: read side, flag = empty
//   SYNC_STAGES  synchroniser depth for ptr_other_gray (>= 2)
// Ports:
//   clk             in   1         this domain's clock
//   rst             in   1         asynchronous active-high reset
//   inc             in   1         push (write side) / pop (read side) request
//   ptr_other_gray  in   ADDR_W+1  Gray pointer from the opposite domain
//   addr            out  ADDR_W    RAM address (low bits of the binary pointer)
//   ptr_gray        out  ADDR_W+1  registered Gray pointer to the opposite domain
//   flag            out  1         registered full / empty
//   level           out  ADDR_W+1  registered occupancy, 0..2**ADDR_W
module gray_ptr_gen
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter bit IS_WRITE    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ADDR_W:0]   ptr_other_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   ptr_gray,
  output logic              flag,
  output logic [ADDR_W:0]   level
);

  localparam int PW = ADDR_W + 1;

  // The write side sits "full" when its Gray pointer equals the read
  // pointer with the top two Gray bits inverted (one lap ahead).
  localparam logic [PW-1:0] FULL_FLIP = {2'b11, {(PW-2){1'b0}}};

  localparam logic FLAG_RST = ~IS_WRITE;

  logic [PW-1:0] bin;
  logic [PW-1:0] sync_ptr;
  logic [PW-1:0] other_bin;
  logic          inc_eff;
  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] gray_nxt;
  logic          flag_nxt;
  logic [PW-1:0] level_nxt;

  ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ptr_other_gray),
    .q   (sync_ptr)
  );

  always_comb begin
    inc_eff   = inc & ~flag;
    bin_nxt   = bin + PW'(inc_eff);
    gray_nxt  = PW'(bin2gray(MAX_W'(bin_nxt)));
    other_bin = PW'(gray2bin(MAX_W'(sync_ptr)));
    flag_nxt  = 1'b0;
    level_nxt = '0;
    // Flag and level both come from the next-state pointer so the flag
    // rises together with the ptr_gray that reaches the boundary.
    if (IS_WRITE) begin
      flag_nxt  = (gray_nxt == (sync_ptr ^ FULL_FLIP));
      level_nxt = bin_nxt - other_bin;
    end else begin
      flag_nxt  = (gray_nxt == sync_ptr);
      level_nxt = other_bin - bin_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      ptr_gray <= '0;
      flag     <= FLAG_RST;
      level    <= '0;
    end else begin
      bin      <= bin_nxt;
      ptr_gray <= gray_nxt;
      flag     <= flag_nxt;
      level    <= level_nxt;
    end
  end

  assign addr = bin[ADDR_W-1:0];

endmodule
